// File: rtl/multicycle_control_if.sv
// Variable-latency memory handshake between the multi-cycle control FSM and
// the instruction/data memories.
interface multicycle_control_if;
  logic imem_req_o;
  logic imem_ready_i;
  logic dmem_req_o;
  logic dmem_we_o;
  logic dmem_ready_i;

  modport master (
    output imem_req_o,
    output dmem_req_o,
    output dmem_we_o,
    input  imem_ready_i,
    input  dmem_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  dmem_req_o,
    input  dmem_we_o,
    output imem_ready_i,
    output dmem_ready_i
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, with a watchdog on memory handshakes.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8,
  parameter int STATE_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.master mem,
  input  logic                 start_i,
  input  logic [5:0]           op_i,
  input  logic                 zero_i,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic [1:0]           pc_src_o,
  output logic                 reg_write_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic                 ext_op_o,
  output logic                 instr_done_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [STATE_W-1:0]   state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_MEM = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_ERR    = 4'd13
  } state_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       instr_done;
    logic       busy;
    logic       err;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Last wait cycle an access may spend without ready before the trap.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl, ctrl_out;
  logic             waiting;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; reset here is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    ctrl.busy = (state_q != S_IDLE) && (state_q != S_ERR);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        ctrl.imem_req  = 1'b1;
        ctrl.alu_src_b = 2'd1;
        if (mem.imem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end

      S_DECODE: begin
        ctrl.alu_src_b = 2'd2;
        ctrl.ext_op    = 1'b1;
        case (op_i)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_ADDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_ERR;
        endcase
      end

      S_EXEC_R: begin
        ctrl.alu_op = 2'b10;
        state_d     = S_WB_R;
      end

      S_EXEC_I: begin
        ctrl.alu_src_b = 2'd2;
        // Only addi and ori reach here: addi adds signed, ori ors unsigned.
        if (op_i == OP_ADDI) begin
          ctrl.alu_op = 2'b00;
          ctrl.ext_op = 1'b1;
        end else begin
          ctrl.alu_op = 2'b11;
          ctrl.ext_op = 1'b0;
        end
        state_d = S_WB_I;
      end

      S_ADDR: begin
        ctrl.alu_src_b = 2'd2;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = 2'b00;
        state_d        = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        ctrl.dmem_req = 1'b1;
        if (mem.dmem_ready_i)        state_d = S_WB_MEM;
        else if (cnt_q == WAIT_LAST) state_d = S_ERR;
      end

      S_MEM_WR: begin
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_we  = 1'b1;
        if (mem.dmem_ready_i) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end

      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end

      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end

      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_op     = 2'b01;
        ctrl.pc_write   = zero_i;
        ctrl.pc_src     = 2'd1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = 2'd2;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end

      S_ERR: begin
        ctrl.err = 1'b1;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // The watchdog counts only while a request is held in place without ready.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign cnt_d   = (waiting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

  // Outputs are forced quiet in the reset cycle so no write fires mid-reset.
  assign ctrl_out = rst_i ? '0 : ctrl;

  assign mem.imem_req_o = ctrl_out.imem_req;
  assign mem.dmem_req_o = ctrl_out.dmem_req;
  assign mem.dmem_we_o  = ctrl_out.dmem_we;
  assign ir_write_o     = ctrl_out.ir_write;
  assign pc_write_o     = ctrl_out.pc_write;
  assign pc_src_o       = ctrl_out.pc_src;
  assign reg_write_o    = ctrl_out.reg_write;
  assign reg_dst_o      = ctrl_out.reg_dst;
  assign mem_to_reg_o   = ctrl_out.mem_to_reg;
  assign alu_src_b_o    = ctrl_out.alu_src_b;
  assign alu_op_o       = ctrl_out.alu_op;
  assign ext_op_o       = ctrl_out.ext_op;
  assign instr_done_o   = ctrl_out.instr_done;
  assign busy_o         = ctrl_out.busy;
  assign err_o          = ctrl_out.err;
  assign state_o        = rst_i ? '0 : STATE_W'(state_q);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle successor of the single-cycle MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback over several cycles, driving datapath enables and mux selects. Instruction and data memory have variable latency and use a req/ready handshake, with a timeout watchdog. It replaces the purely combinational opcode decoder.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before the error trap; 1..255
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT
STATE_W, 4, width of state_o

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  leave IDLE and begin fetching
op_i  in  6  opcode from the instruction register, bits [31:26]
zero_i  in  1  ALU zero flag
imem_ready_i  in  1  instruction memory has read data this cycle
dmem_ready_i  in  1  data memory access completes this cycle
imem_req_o  out  1  instruction fetch request
dmem_req_o  out  1  data memory request
dmem_we_o  out  1  data request is a write
ir_write_o  out  1  latch the instruction register
pc_write_o  out  1  unconditional PC write
pc_src_o  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target
reg_write_o  out  1  register file write enable
reg_dst_o  out  1  destination register: 1 = rd, 0 = rt
mem_to_reg_o  out  1  writeback source: 1 = MDR, 0 = ALUOut
alu_src_b_o  out  2  ALU B input: 0 = rt, 1 = constant 4, 2 = immediate
alu_op_o  out  2  ALU op: 00 = add, 01 = sub, 10 = funct, 11 = or
ext_op_o  out  1  extension: 1 = sign-extend, 0 = zero-extend
instr_done_o  out  1  one-cycle pulse on instruction retire
busy_o  out  1  FSM is not in IDLE or ERR
err_o  out  1  sticky error flag
state_o  out  STATE_W  current state encoding, for debug

Behaviour:
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, EXEC_I = 4, ADDR = 5, MEM_RD = 6, MEM_WR = 7, WB_R = 8, WB_I = 9, WB_MEM = 10, BRANCH = 11, JUMP = 12, ERR = 13.
- Reset: state goes to IDLE, the timeout counter clears and err_o clears. All outputs are 0 during reset and in IDLE, with this default on every enable and select.
- IDLE: moves to FETCH when start_i = 1. start_i is ignored in every other state.
- FETCH: imem_req_o = 1 and alu_src_b_o = 1.
  - When imem_ready_i = 1: ir_write_o = 1, pc_write_o = 1, pc_src_o = 0, next state DECODE.
  - Otherwise the FSM stays in FETCH with the request held.
- DECODE: alu_src_b_o = 2 and ext_op_o = 1, computing the branch target. Next state by op_i:
  - 0x00 goes to EXEC_R.
  - 0x23 (lw) and 0x2B (sw) go to ADDR.
  - 0x08 (addi) and 0x0D (ori) go to EXEC_I.
  - 0x04 (beq) goes to BRANCH.
  - 0x02 (j) goes to JUMP.
  - Any other opcode goes to ERR.
- EXEC_R: alu_op_o = 10, then WB_R.
- EXEC_I: alu_src_b_o = 2.
  - addi: alu_op_o = 00, ext_op_o = 1.
  - ori: alu_op_o = 11, ext_op_o = 0.
  - Next state WB_I.
- ADDR: alu_src_b_o = 2, ext_op_o = 1, alu_op_o = 00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: dmem_req_o = 1. On dmem_ready_i, go to WB_MEM.
- MEM_WR: dmem_req_o = 1 and dmem_we_o = 1. On dmem_ready_i, go to FETCH with instr_done_o = 1.
- WB_R: reg_write_o = 1 and reg_dst_o = 1.
- WB_I: reg_write_o = 1 and reg_dst_o = 0.
- WB_MEM: reg_write_o = 1, reg_dst_o = 0, mem_to_reg_o = 1.
- WB_R, WB_I and WB_MEM all go to FETCH with instr_done_o = 1.
- BRANCH: alu_op_o = 01, alu_src_b_o = 0.
  - pc_write_o = zero_i and pc_src_o = 1.
  - Next state FETCH, with instr_done_o = 1.
- JUMP: pc_write_o = 1, pc_src_o = 2, then FETCH with instr_done_o = 1.
- Latency with ready on first request cycle: R-type 4 cycles, addi/ori 4, lw 5, sw 4, beq 3, j 3.
- Handshake rules:
  - The request stays asserted, with stable dmem_we_o, until ready is seen.
  - Ready is ignored when no request is asserted.
  - ready and req in the same cycle completes the access.
- Timeout counter:
  - It increments each cycle the FSM waits in FETCH, MEM_RD or MEM_WR without ready.
  - It clears on ready and on any state change.
  - When the count reaches MEM_TIMEOUT with ready still low, the next state is ERR; the access gets exactly MEM_TIMEOUT cycles.
- ERR: err_o = 1 and all enables are 0. The FSM stays in ERR until rst_i; start_i has no effect.
- Reset mid-instruction: the FSM returns to IDLE on the next edge. No write enable is asserted in the reset cycle.
- busy_o = 1 in every state except IDLE and ERR.

Test Plan:
- Reset, then start_i pulse, op_i = 0x00, both readies held 1 -> states 1, 2, 3, 8, 1; reg_write_o = 1 and reg_dst_o = 1 in cycle 4; instr_done_o pulses once.
- lw (op 0x23), dmem_ready_i low for 3 cycles then high -> dmem_req_o high for 4 cycles; WB_MEM asserts mem_to_reg_o = 1 and reg_write_o = 1; 8 cycles total.
- beq with zero_i = 0, then with zero_i = 1 -> pc_write_o = 0, then 1 with pc_src_o = 1; both return to FETCH.
- MEM_TIMEOUT = 4, imem_ready_i held 0 -> imem_req_o high for exactly 4 FETCH cycles; state 13 and err_o = 1 thereafter; start_i ignored until rst_i.
- op_i = 0x3F at DECODE -> ERR next cycle, no register write.
- rst_i asserted in MEM_WR with ready low -> next cycle IDLE, all outputs 0, err_o = 0.
